uart_tx: RTL
============

UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter PARITY_EN, default 0, meaning: 1 inserts a parity bit after bit 7.
REQ-002 Parameter PARITY_ODD, default 0, meaning: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-003 Parameter STOP_BITS, default 1, meaning: number of stop bits, legal values 1 or 2.
REQ-004 clk  input  1  system clock; all logic on posedge clk.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 baud_tick  input  1  single-cycle strobe at 16x baud rate.
REQ-007 data_in  input  8  byte to transmit.
REQ-008 data_valid  input  1  source asserts when data_in holds a byte.
REQ-009 data_ready  output  1  high when the one-entry holding buffer is empty.
REQ-010 tx  output  1  serial line; idle high; registered output.
REQ-011 busy  output  1  high while a frame is on the line.
REQ-012 done  output  1  one-clk pulse at the end of each frame's last stop bit.

Function
REQ-013 Frame format SHALL be: 1 start bit (0), 8 data bits LSB first, optional parity bit, then STOP_BITS stop bits (1).
REQ-014 A byte SHALL be accepted on a clk edge with data_valid=1 and data_ready=1, and copied into the holding buffer; data_valid SHALL be ignored when data_ready=0.
REQ-015 FSM states SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE: tx=1, busy=0; when the buffer is full, the FSM SHALL move to START on the next edge, load the shift register from the buffer, and empty the buffer.
REQ-017 The tx output SHALL go low on the edge that enters START, which is one clk after the buffer is loaded.
REQ-018 Each bit SHALL last 16 baud_ticks: a 4-bit tick counter SHALL increment on each baud_tick, and on a baud_tick with counter=15 it SHALL wrap to 0 and advance to the next bit.
REQ-019 The first bit of a frame MAY be shorter than nominal by up to one baud_tick period; no alignment to baud_tick is required.
REQ-020 START SHALL go to DATA; DATA SHALL shift out 8 bits counted by a 3-bit index; after bit 7, DATA SHALL go to PARITY when PARITY_EN=1, otherwise to STOP.
REQ-021 Parity SHALL be the XOR of the 8 data bits for even parity, and its inverse for odd parity.
REQ-022 STOP SHALL hold tx=1 for 16*STOP_BITS ticks; at the end, done SHALL pulse for exactly one clk.
REQ-023 Back-to-back: when the buffer is full at the end of STOP, the FSM SHALL go directly to START on that edge, so no idle gap is inserted.
REQ-024 An accept in the same cycle as the end of STOP with an empty buffer SHALL behave as in REQ-016, giving one clk of idle high.
REQ-025 data_ready SHALL deassert on the edge after an accept and reassert on the edge the buffer is transferred to the shift register, so a second byte can be accepted during a frame.
REQ-026 busy SHALL be high in START, DATA, PARITY and STOP.
REQ-027 baud_tick SHALL be ignored in IDLE, and the tick counter SHALL be 0 on entry to START.
REQ-028 Changes on data_in after acceptance SHALL NOT affect the frame.

Reset
REQ-029 While rst=1, on each edge the block SHALL set tx=1, busy=0, done=0, data_ready=1, FSM=IDLE, and clear the counters, the bit index and the holding buffer.
REQ-030 Reset mid-frame SHALL abort the frame with tx high on the next edge; no done pulse is produced and a buffered byte is discarded.

Verification
REQ-031 Defaults, send 0xA5 -> tx sequence 0,1,0,1,0,0,1,0,1,1, each bit 16 ticks; done pulses once; busy high for about 160 ticks.
REQ-032 PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1; with PARITY_ODD=1 -> parity bit 0; frame is 11 bits.
REQ-033 Send 0x55, then accept 0xAA during bit 3 -> data_ready low until the 0xAA transfer; 0xAA start bit begins on the same edge the 0x55 stop bit ends; two done pulses.
REQ-034 Hold data_valid with buffer full and data_in changing (0x11, 0x22) -> only the first accepted byte is sent; no corruption.
REQ-035 Assert rst during DATA bit 4 -> tx=1 on the next edge, no done pulse; then send 0x3C -> correct frame.
REQ-036 STOP_BITS=2, send 0xFF -> tx low for 16 ticks then high for 16*(8+2) ticks; done at end of second stop bit.

Source files
------------

// File: rtl/uart_tx_if.sv
// uart_tx_if: byte handshake between a data source and the UART transmitter.
//   data_in    - byte offered by the source
//   data_valid - source has a byte on data_in
//   data_ready - transmitter holding buffer is empty
interface uart_tx_if;
   logic [7:0] data_in;
   logic       data_valid;
   logic       data_ready;
   modport master (output data_in, data_valid, input data_ready);
   modport slave (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/uart_tx.sv
// uart_tx: 8-bit UART transmitter with a one-entry holding buffer, optional parity and 1/2 stop bits.
//   clk, rst  - clock and synchronous active-high reset
//   baud_tick - one-cycle strobe at 16x the baud rate
//   s         - byte handshake (data_in, data_valid, data_ready)
//   tx        - registered serial line, idle high
//   busy      - a frame is on the line
//   done      - one-cycle pulse at the end of the last stop bit
module uart_tx #(
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      baud_tick,
   uart_tx_if.slave  s,
   output logic      tx,
   output logic      busy,
   output logic      done
);
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
   state_t     state, state_n;
   logic [7:0] hold, sr;
   logic       full, stop_cnt, adv, last_stop, load, accept, tx_n, done_n;
   logic [3:0] tick;
   logic [2:0] idx, idx_n;
   assign s.data_ready = ~full;
   assign accept       = s.data_valid & ~full;
   assign adv          = baud_tick & (tick == 4'd15);
   assign last_stop    = adv & (stop_cnt == 1'(STOP_BITS - 1));
   // The buffer empties into the shift register on the edge that enters START.
   assign load         = full & ((state == IDLE) | ((state == STOP) & last_stop));
   assign busy         = state != IDLE;
   assign idx_n        = (state == DATA) ? idx + 3'(adv) : 3'd0;
   assign done_n       = (state == STOP) & last_stop;
   always_comb begin
      state_n = state;
      case (state)
         IDLE:    if (full) state_n = START;
         START:   if (adv) state_n = DATA;
         DATA:    if (adv && idx == 3'd7) state_n = (PARITY_EN != 0) ? PARITY : STOP;
         PARITY:  if (adv) state_n = STOP;
         STOP:    if (last_stop) state_n = full ? START : IDLE;
         default: state_n = IDLE;
      endcase
      // tx is registered, so it is derived from the state being entered.
      tx_n = (state_n == START)  ? 1'b0 :
             (state_n == DATA)   ? sr[idx_n] :
             (state_n == PARITY) ? (^sr) ^ 1'(PARITY_ODD) : 1'b1;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tx       <= 1'b1;
         done     <= 1'b0;
         full     <= 1'b0;
         hold     <= '0;
         sr       <= '0;
         tick     <= '0;
         idx      <= '0;
         stop_cnt <= 1'b0;
      end else begin
         state    <= state_n;
         tx       <= tx_n;
         done     <= done_n;
         if (load) begin
            sr   <= hold;
            full <= 1'b0;
         end else if (accept) begin
            hold <= s.data_in;
            full <= 1'b1;
         end
         // Counter is held at zero in IDLE and wraps to zero at each bit end,
         // so every START is entered with a cleared counter.
         tick     <= (state == IDLE) ? 4'd0 : tick + 4'(baud_tick);
         idx      <= idx_n;
         stop_cnt <= ((state == STOP) && !last_stop) ? stop_cnt ^ adv : 1'b0;
      end
   end
endmodule
